// File: rtl/pla_risc_opcode_fetch.sv
// pla_risc_opcode_fetch: instruction-fetch front end for the RISC control-decode PLA.
// Issues sequential fetch requests while there is space for their replies, buffers the
// returned opcodes in a prefetch FIFO, and presents the oldest opcode to the decoder.
// Build option: define FETCH_HALT_EN to add the 'halted' output. In that build a buffered
// 8'hFF opcode stops further request issue until the next redirect or reset.
// Handshake rule on both the memory request and the decoder side: a transfer happens on
// a rising edge where valid && ready. Valid never depends on ready. While valid is high
// and ready is low, the payload holds steady.
module pla_risc_opcode_fetch #(
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [7:0]        imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [7:0]        op,
    output logic [ADDR_W-1:0] op_pc,
`ifdef FETCH_HALT_EN
    output logic              halted,
`endif
    output logic              dbg_state_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [SUM_W-1:0]  CREDITS = SUM_W'(DEPTH);
    localparam logic [CNT_W-1:0]  FULL    = CNT_W'(DEPTH);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  rem_cnt;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  head_idx;
    logic [7:0]        op_q, op_d;
    logic [ADDR_W-1:0] op_pc_q, op_pc_d;
    logic              started_q;

    logic [7:0]        mem_op_q [DEPTH];
    logic [ADDR_W-1:0] mem_pc_q [DEPTH];

    logic req_hs;
    logic push;
    logic pop;
    logic drop;
    logic issue_hold;
    logic credit_ok;

`ifdef FETCH_HALT_EN
    logic halted_q;
    assign issue_hold = halted_q;
    assign halted     = halted_q;
`else
    assign issue_hold = 1'b0;
`endif

    // Credit rule: FIFO entries plus replies still owed never exceed DEPTH.
    // This is what makes an overflowing push impossible.
    assign credit_ok      = ({1'b0, count_q} + {1'b0, outstanding_q}) < CREDITS;
    // started_q keeps the first cycle after reset quiet.
    assign imem_req_valid = ~rst & started_q & (state_q == ST_FETCH) & ~redirect_valid
                          & ~issue_hold & credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_hs         = imem_req_valid & imem_req_ready;
    assign drop           = imem_rsp_valid & (drop_cnt_q != '0);
    assign push           = imem_rsp_valid & (drop_cnt_q == '0) & ~redirect_valid;
    assign op_valid       = (count_q != '0);
    assign pop            = op_valid & op_ready & ~redirect_valid;
    assign op             = op_q;
    assign op_pc          = op_pc_q;
    assign dbg_state_o    = state_q;

    // Next-state logic. Redirect wins over everything except reset. The registered head
    // (op_q/op_pc_q) is reloaded with whatever entry will be oldest after this edge.
    always_comb begin
        outstanding_d = outstanding_q;
        if (req_hs && !imem_rsp_valid) begin
            outstanding_d = outstanding_q + CNT_ONE;
        end else if (!req_hs && imem_rsp_valid) begin
            outstanding_d = outstanding_q - CNT_ONE;
        end

        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_cnt_d = drop_cnt_q;
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        op_d       = op_q;
        op_pc_d    = op_pc_q;
        rem_cnt    = count_q - (pop ? CNT_ONE : '0);
        head_idx   = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        if (redirect_valid) begin
            // Every reply still owed, including any request accepted now and excluding
            // any reply arriving now, belongs to the old stream and gets dropped.
            pc_d       = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_cnt_d = outstanding_d;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            if ((state_q == ST_FLUSH) || (outstanding_d != '0)) begin
                state_d = ST_FLUSH;
            end else begin
                state_d = ST_FETCH;
            end
        end else begin
            if (req_hs) begin
                pc_d = pc_q + PC_ONE;
            end
            if (drop) begin
                drop_cnt_d = drop_cnt_q - CNT_ONE;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + PC_ONE;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            count_d = rem_cnt + (push ? CNT_ONE : '0);
            if (count_d != '0) begin
                if (rem_cnt == '0) begin
                    // The only remaining entry is the one arriving now.
                    op_d    = imem_rsp_data;
                    op_pc_d = rsp_pc_q;
                end else begin
                    op_d    = mem_op_q[head_idx];
                    op_pc_d = mem_pc_q[head_idx];
                end
            end
            if ((state_q == ST_FLUSH) && (drop_cnt_q == '0)) begin
                state_d = ST_FETCH;
            end
        end
    end

    // Control state, FSM and registered decoder outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            op_q          <= '0;
            op_pc_q       <= '0;
            started_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            op_q          <= op_d;
            op_pc_q       <= op_pc_d;
            started_q     <= 1'b1;
        end
    end

    // Prefetch storage. Each entry holds the opcode and the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_op_q[wr_ptr_q] <= imem_rsp_data;
            mem_pc_q[wr_ptr_q] <= rsp_pc_q;
        end
    end

`ifdef FETCH_HALT_EN
    // Halt latch: set by a buffered 8'hFF, cleared by redirect or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            halted_q <= 1'b0;
        end else if (push && (imem_rsp_data == 8'hFF)) begin
            halted_q <= 1'b1;
        end
    end
`endif

    fifo_no_overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == FULL)));

endmodule

// File: tb/tb_pla_risc_opcode_fetch.sv
// tb_pla_risc_opcode_fetch: directed bench for pla_risc_opcode_fetch (DEPTH=4, ADDR_W=8).
// The memory model returns addr ^ 8'hA5, optionally 8'hFF at address 2, with a
// programmable in-order latency. Delivered opcodes are checked against a queue of
// hand-computed {op_pc, op} pairs.
module tb_pla_risc_opcode_fetch;

  logic       clk;
  logic       rst;
  logic       imem_req_valid;
  logic       imem_req_ready;
  logic [7:0] imem_req_addr;
  logic       imem_rsp_valid;
  logic [7:0] imem_rsp_data;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] op;
  logic [7:0] op_pc;
  logic       dbg_state;
`ifdef FETCH_HALT_EN
  logic       halted;
`endif

  pla_risc_opcode_fetch #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op             (op),
    .op_pc          (op_pc),
`ifdef FETCH_HALT_EN
    .halted         (halted),
`endif
    .dbg_state_o    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // scoreboard and memory-model state
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         lat = 1;
  logic       halt_img = 1'b0;
  int         pend_due[$];
  logic [7:0] pend_dat[$];
  logic [7:0] req_log[$];
  int         req_cyc[$];
  int         cons_cyc[$];
  int         n_req = 0;
  logic [15:0] exp_q[$];
  logic       prev_hold_v = 1'b0;
  logic [15:0] prev_pair = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [7:0] a);
    if (halt_img && (a == 8'h02)) return 8'hFF;
    return a ^ 8'hA5;
  endfunction

  task automatic push_exp(input logic [7:0] pc, input logic [7:0] d);
    exp_q.push_back({pc, d});
  endtask

  // driver: one clock cycle, entered and left at the falling edge
  task automatic cycle();
    int due;
    if ((pend_due.size() != 0) && (pend_due[0] == cyc)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend_dat.pop_front();
      void'(pend_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 8'h00;
    end
    #1;
    if (prev_hold_v) check("op_hold", 32'({op_pc, op}), 32'(prev_pair));
    prev_hold_v = op_valid && !op_ready && !redirect_valid && !rst;
    prev_pair   = {op_pc, op};
    if (imem_req_valid && imem_req_ready && !rst) begin
      due = cyc + lat;
      if ((pend_due.size() != 0) && (due <= pend_due[$])) due = pend_due[$] + 1;
      pend_due.push_back(due);
      pend_dat.push_back(mem_byte(imem_req_addr));
      req_log.push_back(imem_req_addr);
      req_cyc.push_back(cyc);
      n_req++;
    end
    if (op_valid && op_ready && !redirect_valid && !rst) begin
      cons_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("op_extra", 32'(op_valid), 32'(0));
      else check("op", 32'({op_pc, op}), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    redirect_valid = 1'b0;
    repeat (n) cycle();
    pend_due.delete();
    pend_dat.delete();
    req_log.delete();
    req_cyc.delete();
    cons_cyc.delete();
    exp_q.delete();
    n_req = 0;
    rst = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 8'h00;
  endtask

  task automatic drain(input string tag, input int budget);
    int b = 0;
    while ((exp_q.size() != 0) && (b < budget)) begin
      cycle();
      b++;
    end
    if (exp_q.size() != 0) check(tag, 32'(exp_q.size()), 32'(0));
    exp_q.delete();
  endtask

  task automatic redirect_to(input logic [7:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int b;
    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 8'h00;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    op_ready = 1'b0;

    // 1: reset, then streaming with 1-cycle latency
    do_reset(2);
    #1;
    check("rst_op_valid", 32'(op_valid), 32'(0));
    check("rst_req_valid", 32'(imem_req_valid), 32'(0));
    check("rst_op", 32'(op), 32'(0));
    check("rst_op_pc", 32'(op_pc), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(0));
    lat = 1;
    op_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(8'(i), 8'(i) ^ 8'hA5);
    drain("t1_timeout", 40);
    op_ready = 1'b0;
    if ((cons_cyc.size() >= 8) && (req_cyc.size() >= 1)) begin
      check("t1_fill", 32'(cons_cyc[0] - req_cyc[0]), 32'(2));
      check("t1_rate", 32'(cons_cyc[7] - cons_cyc[0]), 32'(7));
    end else begin
      check("t1_count", 32'(cons_cyc.size()), 32'(8));
    end

    // 2: backpressure fills the FIFO, then drain and resume at pc 4
    do_reset(2);
    op_ready = 1'b0;
    repeat (10) cycle();
    #1;
    check("t2_nreq", 32'(n_req), 32'(4));
    check("t2_req_valid", 32'(imem_req_valid), 32'(0));
    check("t2_op_valid", 32'(op_valid), 32'(1));
    check("t2_op", 32'(op), 32'hA5);
    check("t2_op_pc", 32'(op_pc), 32'(0));
    op_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_exp(8'(i), 8'(i) ^ 8'hA5);
    drain("t2_timeout", 40);
    op_ready = 1'b0;
    if (req_log.size() > 4) check("t2_resume_pc", 32'(req_log[4]), 32'(4));
    else check("t2_resume_nreq", 32'(req_log.size()), 32'(5));

    // 3: redirect to 0x40 with two requests in flight (3-cycle latency)
    do_reset(2);
    lat = 3;
    op_ready = 1'b1;
    b = 0;
    while ((n_req < 2) && (b < 20)) begin
      cycle();
      b++;
    end
    check("t3_setup_nreq", 32'(n_req), 32'(2));
    redirect_to(8'h40);
    #1;
    check("t3_state_flush", 32'(dbg_state), 32'(1));
    check("t3_op_valid", 32'(op_valid), 32'(0));
    check("t3_no_req_in_redirect", 32'(n_req), 32'(2));
    push_exp(8'h40, 8'hE5);
    push_exp(8'h41, 8'hE4);
    drain("t3_timeout", 40);
    op_ready = 1'b0;
    if (req_log.size() > 2) check("t3_first_new_pc", 32'(req_log[2]), 32'h40);
    else check("t3_new_nreq", 32'(req_log.size()), 32'(3));

    // 4: PC wrap after redirect to 0xFE; op_ready high in the redirect cycle
    lat = 1;
    op_ready = 1'b1;
    redirect_to(8'hFE);
    #1;
    check("t4_op_valid", 32'(op_valid), 32'(0));
    push_exp(8'hFE, 8'h5B);
    push_exp(8'hFF, 8'h5A);
    push_exp(8'h00, 8'hA5);
    push_exp(8'h01, 8'hA4);
    drain("t4_timeout", 40);
    op_ready = 1'b0;

    // 5: reset with two buffered opcodes and two replies owed
    do_reset(2);
    lat = 3;
    op_ready = 1'b0;
    b = 0;
    while (!((n_req == 4) && (pend_due.size() == 2)) && (b < 20)) begin
      cycle();
      b++;
    end
    #1;
    check("t5_setup_op_valid", 32'(op_valid), 32'(1));
    do_reset(1);
    #1;
    check("t5_op_valid", 32'(op_valid), 32'(0));
    check("t5_req_valid", 32'(imem_req_valid), 32'(0));
    check("t5_op", 32'(op), 32'(0));
    check("t5_op_pc", 32'(op_pc), 32'(0));
    b = 0;
    while ((n_req == 0) && (b < 10)) begin
      cycle();
      b++;
    end
    if (req_log.size() > 0) check("t5_first_pc", 32'(req_log[0]), 32'(0));
    else check("t5_nreq", 32'(n_req), 32'(1));

    // 6: opcode 8'hFF at address 2
    do_reset(2);
    halt_img = 1'b1;
    lat = 1;
    op_ready = 1'b1;
`ifdef FETCH_HALT_EN
    push_exp(8'h00, 8'hA5);
    push_exp(8'h01, 8'hA4);
    push_exp(8'h02, 8'hFF);
    push_exp(8'h03, 8'hA6);
    drain("t6_timeout", 40);
    repeat (5) cycle();
    #1;
    check("t6_halted", 32'(halted), 32'(1));
    check("t6_nreq", 32'(n_req), 32'(4));
    check("t6_req_valid", 32'(imem_req_valid), 32'(0));
    redirect_to(8'h10);
    #1;
    check("t6_halt_clear", 32'(halted), 32'(0));
    push_exp(8'h10, 8'hB5);
    drain("t6_resume_timeout", 20);
    if (req_log.size() > 4) check("t6_resume_pc", 32'(req_log[4]), 32'h10);
    else check("t6_resume_nreq", 32'(req_log.size()), 32'(5));
`else
    push_exp(8'h00, 8'hA5);
    push_exp(8'h01, 8'hA4);
    push_exp(8'h02, 8'hFF);
    push_exp(8'h03, 8'hA6);
    push_exp(8'h04, 8'hA1);
    push_exp(8'h05, 8'hA0);
    drain("t6_timeout", 40);
`endif
    op_ready = 1'b0;
    halt_img = 1'b0;

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
